change_dispenser: RTL

- Coin-out counterpart to the vending machine's coin-in path. The machine accepts nickels, dimes and quarters and dispenses burritos; this block pays a change or refund amount back out as coins.
- Takes a cents amount, then pays it out greedily (largest coin first) through a valid/ready handshake to the coin ejector mechanism.
- Tracks per-coin stock and reports completion or failure to the vending FSM.

---
 rtl/change_dispenser.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Pays out a cents amount greedily (quarter, dime, nickel) through a valid/ready
// coin ejector handshake, tracking per-coin stock and reporting done/fail.
module change_dispenser #(
    parameter int Q_STOCK = 20,
    parameter int D_STOCK = 20,
    parameter int N_STOCK = 20,
    parameter int STOCK_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [6:0]         amount,
    input  logic               refill,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [6:0]         remaining,
    output logic               coin_valid,
    output logic [1:0]         coin_type,
    input  logic               coin_ready,
    output logic [STOCK_W-1:0] q_cnt,
    output logic [STOCK_W-1:0] d_cnt,
    output logic [STOCK_W-1:0] n_cnt
);

    // state  | meaning
    // IDLE   | waiting for start, honours refill
    // CHECK  | reject amounts that are not a multiple of 5
    // SELECT | pick the largest coin that fits and is in stock
    // EJECT  | hold coin request until the mechanism takes it
    // DONE   | one-cycle done pulse
    // FAIL   | one-cycle fail pulse
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SELECT, S_EJECT, S_DONE, S_FAIL
    } state_t;

    localparam logic [1:0] COIN_N = 2'b00;
    localparam logic [1:0] COIN_D = 2'b01;
    localparam logic [1:0] COIN_Q = 2'b10;
    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_MOD5  = 2'b01;
    localparam logic [1:0] CODE_STOCK = 2'b10;
    localparam logic [STOCK_W-1:0] Q_INIT  = STOCK_W'(Q_STOCK);
    localparam logic [STOCK_W-1:0] D_INIT  = STOCK_W'(D_STOCK);
    localparam logic [STOCK_W-1:0] N_INIT  = STOCK_W'(N_STOCK);
    localparam logic [STOCK_W-1:0] ONE     = STOCK_W'(1);
    localparam logic [STOCK_W-1:0] ZERO    = '0;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [6:0]         remaining_q, remaining_d;
    logic               coin_valid_q, coin_valid_d;
    logic [1:0]         coin_type_q, coin_type_d;
    logic [STOCK_W-1:0] q_cnt_q, q_cnt_d;
    logic [STOCK_W-1:0] d_cnt_q, d_cnt_d;
    logic [STOCK_W-1:0] n_cnt_q, n_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= CODE_NONE;
            remaining_q  <= 7'd0;
            coin_valid_q <= 1'b0;
            coin_type_q  <= COIN_N;
            q_cnt_q      <= Q_INIT;
            d_cnt_q      <= D_INIT;
            n_cnt_q      <= N_INIT;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            remaining_q  <= remaining_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            q_cnt_q      <= q_cnt_d;
            d_cnt_q      <= d_cnt_d;
            n_cnt_q      <= n_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        fail_code_d  = fail_code_q;
        remaining_d  = remaining_q;
        coin_valid_d = coin_valid_q;
        coin_type_d  = coin_type_q;
        q_cnt_d      = q_cnt_q;
        d_cnt_d      = d_cnt_q;
        n_cnt_d      = n_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    q_cnt_d = Q_INIT;
                    d_cnt_d = D_INIT;
                    n_cnt_d = N_INIT;
                end
                if (start) begin
                    remaining_d = amount;
                    busy_d      = 1'b1;
                    fail_code_d = CODE_NONE;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                // remaining still holds the captured amount here
                if ((remaining_q % 7'd5) != 7'd0) begin
                    fail_d      = 1'b1;
                    fail_code_d = CODE_MOD5;
                    state_d     = S_FAIL;
                end else if (remaining_q == 7'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == 7'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (remaining_q >= 7'd25 && q_cnt_q != ZERO) begin
                    coin_type_d  = COIN_Q;
                    coin_valid_d = 1'b1;
                    state_d      = S_EJECT;
                end else if (remaining_q >= 7'd10 && d_cnt_q != ZERO) begin
                    coin_type_d  = COIN_D;
                    coin_valid_d = 1'b1;
                    state_d      = S_EJECT;
                end else if (remaining_q >= 7'd5 && n_cnt_q != ZERO) begin
                    coin_type_d  = COIN_N;
                    coin_valid_d = 1'b1;
                    state_d      = S_EJECT;
                end else begin
                    fail_d      = 1'b1;
                    fail_code_d = CODE_STOCK;
                    state_d     = S_FAIL;
                end
            end
            S_EJECT: begin
                if (coin_ready) begin
                    coin_valid_d = 1'b0;
                    state_d      = S_SELECT;
                    case (coin_type_q)
                        COIN_Q: begin
                            q_cnt_d     = q_cnt_q - ONE;
                            remaining_d = remaining_q - 7'd25;
                        end
                        COIN_D: begin
                            d_cnt_d     = d_cnt_q - ONE;
                            remaining_d = remaining_q - 7'd10;
                        end
                        COIN_N: begin
                            n_cnt_d     = n_cnt_q - ONE;
                            remaining_d = remaining_q - 7'd5;
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_code  = fail_code_q;
    assign remaining  = remaining_q;
    assign coin_valid = coin_valid_q;
    assign coin_type  = coin_type_q;
    assign q_cnt      = q_cnt_q;
    assign d_cnt      = d_cnt_q;
    assign n_cnt      = n_cnt_q;

endmodule
